// File: rtl/note_scheduler.sv
// Falling-note sequencer: note pool, per-frame movement, LFSR lane spawning and pad judging.
// Build option NOTE_SCHED_COMBO_EN adds the consecutive-hit combo counter; otherwise combo reads 0.
module note_scheduler #(
   parameter int NUM_NOTES    = 8,
   parameter int SPAWN_Y      = 480,
   parameter int TARGET_Y     = 36,
   parameter int HIT_WIN      = 12,
   parameter int SPEED        = 2,
   parameter int SPAWN_PERIOD = 30
) (
   input  logic                    clk,
   input  logic                    iRST_N,
   input  logic                    vga_vs,
   input  logic                    go_switch,
   input  logic [3:0]              pad,
   output logic [NUM_NOTES-1:0]    note_valid,
   output logic [2*NUM_NOTES-1:0]  note_lane,
   output logic [10*NUM_NOTES-1:0] note_y,
   output logic [15:0]             score,
   output logic [7:0]              combo,
   output logic                    hit_pulse,
   output logic                    miss_pulse,
   output logic                    busy
);

   localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
   localparam logic [9:0] EXPIRE_Y = 10'(TARGET_Y - HIT_WIN + SPEED);
   localparam logic [9:0] TGT_Y    = 10'(TARGET_Y);
   localparam logic [9:0] WIN      = 10'(HIT_WIN);
   localparam logic [9:0] STEP     = 10'(SPEED);
   localparam logic [9:0] START_Y  = 10'(SPAWN_Y);
   localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NUM_NOTES - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPAWN_PERIOD - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, JUDGE = 2'd1, MOVE = 2'd2, SPAWN = 2'd3} state_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [9:0] row_dist(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   logic [3:0] pad_s1, pad_s2, pad_prev;
   logic       go_s1, go_s2, go_prev;
   logic       vs_s1, vs_s2, vs_prev;
   logic [3:0] pad_rise;
   logic       vs_fall, go_rise;

   state_t           state, state_n;
   logic [IDX_W-1:0] slot_k, k_n;
   logic [NUM_NOTES-1:0] valid_r, valid_n;
   logic [1:0]       lane_r [NUM_NOTES];
   logic [1:0]       lane_n [NUM_NOTES];
   logic [9:0]       y_r [NUM_NOTES];
   logic [9:0]       y_n [NUM_NOTES];
   logic [15:0]      score_r, score_n;
   logic             hit_r, hit_n, miss_r, miss_n, busy_r;
   logic [7:0]       lfsr_r, lfsr_n, spawn_lfsr;
   logic [CNT_W-1:0] frame_cnt, cnt_n;
   logic [3:0]       pad_pend, pad_pend_n;
   logic             frame_pend, frame_pend_n;
   logic [1:0]       sel_lane;
   logic             sel_found, match_found, free_found;

   // Two-flop synchronizers plus one history stage for edge detection.
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         pad_s1   <= 4'd0;
         pad_s2   <= 4'd0;
         pad_prev <= 4'd0;
         go_s1    <= 1'b0;
         go_s2    <= 1'b0;
         go_prev  <= 1'b0;
         vs_s1    <= 1'b0;
         vs_s2    <= 1'b0;
         vs_prev  <= 1'b0;
      end else begin
         pad_s1   <= pad;
         pad_s2   <= pad_s1;
         pad_prev <= pad_s2;
         go_s1    <= go_switch;
         go_s2    <= go_s1;
         go_prev  <= go_s2;
         vs_s1    <= vga_vs;
         vs_s2    <= vs_s1;
         vs_prev  <= vs_s2;
      end
   end

   assign pad_rise = pad_s2 & ~pad_prev;
   assign vs_fall  = vs_prev & ~vs_s2;
   assign go_rise  = go_s2 & ~go_prev;

   // Next-state and datapath: restart/pause override, then JUDGE/MOVE/SPAWN work.
   always_comb begin
      state_n      = state;
      k_n          = slot_k;
      valid_n      = valid_r;
      lane_n       = lane_r;
      y_n          = y_r;
      score_n      = score_r;
      hit_n        = 1'b0;
      miss_n       = 1'b0;
      lfsr_n       = lfsr_r;
      cnt_n        = frame_cnt;
      pad_pend_n   = pad_pend | pad_rise;
      frame_pend_n = frame_pend | vs_fall;
      sel_lane     = 2'd0;
      sel_found    = 1'b0;
      match_found  = 1'b0;
      free_found   = 1'b0;
      spawn_lfsr   = lfsr_step(lfsr_r);
      if (go_rise) begin
         state_n = IDLE;
         k_n     = '0;
         valid_n = '0;
         for (int i = 0; i < NUM_NOTES; i++) begin
            lane_n[i] = 2'd0;
            y_n[i]    = 10'd0;
         end
         score_n      = 16'd0;
         cnt_n        = '0;
         pad_pend_n   = 4'd0;
         frame_pend_n = 1'b0;
      end else if (!go_s2) begin
         state_n      = IDLE;
         k_n          = '0;
         pad_pend_n   = 4'd0;
         frame_pend_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pad_pend != 4'd0) begin
                  state_n = JUDGE;
               end else if (frame_pend) begin
                  // A tick landing in the same cycle as the hand-off stays pending.
                  frame_pend_n = vs_fall;
                  k_n          = '0;
                  state_n      = MOVE;
               end else begin
                  state_n = IDLE;
               end
            end
            JUDGE: begin
               for (int b = 0; b < 4; b++) begin
                  if (!sel_found && pad_pend[b]) begin
                     sel_found = 1'b1;
                     sel_lane  = 2'(b);
                  end else begin
                     sel_found = sel_found;
                  end
               end
               pad_pend_n = (pad_pend & ~(4'd1 << sel_lane)) | pad_rise;
               for (int i = 0; i < NUM_NOTES; i++) begin
                  if (!match_found && valid_r[i] && (lane_r[i] == sel_lane) &&
                      (row_dist(y_r[i], TGT_Y) <= WIN)) begin
                     match_found = 1'b1;
                     valid_n[i]  = 1'b0;
                     lane_n[i]   = 2'd0;
                     y_n[i]      = 10'd0;
                  end else begin
                     match_found = match_found;
                  end
               end
               if (match_found) begin
                  hit_n   = 1'b1;
                  score_n = (score_r != 16'hFFFF) ? (score_r + 16'd1) : score_r;
               end else begin
                  miss_n = 1'b1;
               end
               state_n = IDLE;
            end
            MOVE: begin
               if (valid_r[slot_k]) begin
                  if (y_r[slot_k] < EXPIRE_Y) begin
                     valid_n[slot_k] = 1'b0;
                     lane_n[slot_k]  = 2'd0;
                     y_n[slot_k]     = 10'd0;
                     miss_n          = 1'b1;
                  end else begin
                     y_n[slot_k] = y_r[slot_k] - STEP;
                  end
               end else begin
                  y_n[slot_k] = y_r[slot_k];
               end
               if (slot_k == LAST_K) begin
                  k_n     = '0;
                  state_n = SPAWN;
               end else begin
                  k_n     = slot_k + IDX_W'(1);
                  state_n = MOVE;
               end
            end
            SPAWN: begin
               if (frame_cnt == LAST_CNT) begin
                  cnt_n  = '0;
                  lfsr_n = spawn_lfsr;
                  for (int i = 0; i < NUM_NOTES; i++) begin
                     if (!free_found && !valid_r[i]) begin
                        free_found = 1'b1;
                        valid_n[i] = 1'b1;
                        lane_n[i]  = spawn_lfsr[1:0];
                        y_n[i]     = START_Y;
                     end else begin
                        free_found = free_found;
                     end
                  end
               end else begin
                  cnt_n = frame_cnt + CNT_W'(1);
               end
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // State, note pool and score registers.
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         state      <= IDLE;
         slot_k     <= '0;
         valid_r    <= '0;
         lane_r     <= '{default: 2'd0};
         y_r        <= '{default: 10'd0};
         score_r    <= 16'd0;
         hit_r      <= 1'b0;
         miss_r     <= 1'b0;
         busy_r     <= 1'b0;
         lfsr_r     <= 8'hA5;
         frame_cnt  <= '0;
         pad_pend   <= 4'd0;
         frame_pend <= 1'b0;
      end else begin
         state      <= state_n;
         slot_k     <= k_n;
         valid_r    <= valid_n;
         lane_r     <= lane_n;
         y_r        <= y_n;
         score_r    <= score_n;
         hit_r      <= hit_n;
         miss_r     <= miss_n;
         busy_r     <= (state_n != IDLE);
         lfsr_r     <= lfsr_n;
         frame_cnt  <= cnt_n;
         pad_pend   <= pad_pend_n;
         frame_pend <= frame_pend_n;
      end
   end

`ifdef NOTE_SCHED_COMBO_EN
   logic [7:0] combo_r;

   // Combo: cleared by any miss or restart, saturating increment on a hit.
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         combo_r <= 8'd0;
      end else if (go_rise || miss_n) begin
         combo_r <= 8'd0;
      end else if (hit_n && (combo_r != 8'hFF)) begin
         combo_r <= combo_r + 8'd1;
      end else begin
         combo_r <= combo_r;
      end
   end

   assign combo = combo_r;
`else
   assign combo = 8'd0;
`endif

   // Flatten the slot arrays onto the renderer buses.
   always_comb begin
      note_lane = '0;
      note_y    = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         note_lane[2*i +: 2]  = lane_r[i];
         note_y[10*i +: 10]   = y_r[i];
      end
   end

   assign note_valid = valid_r;
   assign score      = score_r;
   assign hit_pulse  = hit_r;
   assign miss_pulse = miss_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: transaction-level note pool model plus directed literal checks.
module tb_note_scheduler;
   localparam int N   = 8;
   localparam int SPN = 480;
   localparam int TGT = 36;
   localparam int WIN = 12;
   localparam int SPD = 2;
   localparam int PER = 30;
`ifdef NOTE_SCHED_COMBO_EN
   localparam int COMBO_ON = 1;
`else
   localparam int COMBO_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic vs = 1'b1;
   logic vs2 = 1'b1;
   logic go = 1'b0;
   logic [3:0] pad = 4'd0;
   logic [3:0] pad2 = 4'd0;

   logic [N-1:0]    note_valid, note_valid2;
   logic [2*N-1:0]  note_lane, note_lane2;
   logic [10*N-1:0] note_y, note_y2;
   logic [15:0]     score, score2;
   logic [7:0]      combo, combo2;
   logic            hit_pulse, miss_pulse, busy, hit2, miss2, busy2;

   note_scheduler dut (
      .clk(clk), .iRST_N(rst_n), .vga_vs(vs), .go_switch(go), .pad(pad),
      .note_valid(note_valid), .note_lane(note_lane), .note_y(note_y),
      .score(score), .combo(combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .busy(busy)
   );

   // Wide hit window around a high target so a full pool never expires.
   note_scheduler #(.NUM_NOTES(8), .SPAWN_Y(480), .TARGET_Y(400), .HIT_WIN(90),
                    .SPEED(2), .SPAWN_PERIOD(2)) dut2 (
      .clk(clk), .iRST_N(rst_n), .vga_vs(vs2), .go_switch(go), .pad(pad2),
      .note_valid(note_valid2), .note_lane(note_lane2), .note_y(note_y2),
      .score(score2), .combo(combo2), .hit_pulse(hit2), .miss_pulse(miss2), .busy(busy2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;
   int hit_cnt = 0;
   int miss_cnt = 0;

   int m_valid [N];
   int m_lane [N];
   int m_y [N];
   int m_score, m_combo, m_lfsr, m_cnt;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lfsr_next(input int l);
      int fb;
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      return ((l << 1) & 8'hFF) | fb;
   endfunction

   function automatic int exp_combo();
      return (COMBO_ON != 0) ? m_combo : 0;
   endfunction

   task automatic model_clear_pool();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_lane[i]  = 0;
         m_y[i]     = 0;
      end
      m_score = 0;
      m_combo = 0;
      m_cnt   = 0;
   endtask

   task automatic model_reset();
      model_clear_pool();
      m_lfsr = 8'hA5;
   endtask

   task automatic model_frame(output int exp_miss);
      int slot;
      exp_miss = 0;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] != 0) begin
            if (m_y[i] < TGT - WIN + SPD) begin
               m_valid[i] = 0;
               m_combo    = 0;
               exp_miss++;
            end else begin
               m_y[i] = m_y[i] - SPD;
            end
         end
      end
      m_cnt++;
      if (m_cnt == PER) begin
         m_cnt  = 0;
         m_lfsr = lfsr_next(m_lfsr);
         slot   = -1;
         for (int i = 0; i < N; i++)
            if (slot < 0 && m_valid[i] == 0) slot = i;
         if (slot >= 0) begin
            m_valid[slot] = 1;
            m_lane[slot]  = m_lfsr & 3;
            m_y[slot]     = SPN;
         end
      end
   endtask

   task automatic model_press(input int lane, output int hit);
      int found, d;
      found = -1;
      for (int i = 0; i < N; i++) begin
         d = (m_y[i] >= TGT) ? m_y[i] - TGT : TGT - m_y[i];
         if (found < 0 && m_valid[i] != 0 && m_lane[i] == lane && d <= WIN) found = i;
      end
      if (found >= 0) begin
         m_valid[found] = 0;
         m_score = (m_score < 65535) ? m_score + 1 : m_score;
         m_combo = (m_combo < 255) ? m_combo + 1 : m_combo;
         hit = 1;
      end else begin
         m_combo = 0;
         hit = 0;
      end
   endtask

   // Pulse counters for the primary instance.
   always @(negedge clk) begin
      if (hit_pulse) hit_cnt++;
      if (miss_pulse) miss_cnt++;
   end

   // Compare the primary instance against the model whenever it is idle and in step.
   always @(negedge clk) begin : cmp_proc
      int vexp;
      if (check_en && !busy) begin
         vexp = 0;
         for (int i = 0; i < N; i++)
            if (m_valid[i] != 0) vexp = vexp | (1 << i);
         chk("pool_valid", note_valid, vexp);
         chk("pool_score", score, m_score);
         chk("pool_combo", combo, exp_combo());
         for (int i = 0; i < N; i++) begin
            if (m_valid[i] != 0) begin
               chk("pool_lane", note_lane[2*i +: 2], m_lane[i]);
               chk("pool_y", note_y[10*i +: 10], m_y[i]);
            end
         end
      end
   end

   task automatic wait_done(input int which, output int nbusy);
      bit seen;
      logic b;
      seen  = 1'b0;
      nbusy = 0;
      b     = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1;
         b = (which == 1) ? busy : busy2;
         if (b) begin
            seen = 1'b1;
            nbusy++;
         end else if (seen) begin
            break;
         end
      end
      chk("work_completed", (seen && !b) ? 1 : 0, 1);
   endtask

   task automatic frame(input int which);
      int nb, em, m0;
      em = 0;
      m0 = miss_cnt;
      if (which == 1) vs = 1'b0; else vs2 = 1'b0;
      wait_done(which, nb);
      if (which == 1) model_frame(em);
      if (which == 1) vs = 1'b1; else vs2 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("frame_busy_cycles", nb, N + 1);
      if (which == 1) chk("expiry_miss_count", miss_cnt - m0, em);
   endtask

   task automatic press(input int lane);
      int nb, h, h0, m0;
      h0 = hit_cnt;
      m0 = miss_cnt;
      pad[lane] = 1'b1;
      wait_done(1, nb);
      model_press(lane, h);
      pad[lane] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("judge_busy_cycles", nb, 1);
      chk("hit_pulse_count", hit_cnt - h0, h);
      chk("miss_pulse_count", miss_cnt - m0, 1 - h);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, h0, m0, h1, h2, em;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", note_valid, 0);
      chk("rst_score", score, 0);
      chk("rst_combo", combo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
      chk("rst_y_nonzero", (note_y != '0) ? 1 : 0, 0);
      rst_n = 1'b1;
      go    = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_en = 1'b1;

      // First spawn after one full period: lane from LFSR A5 -> 4A.
      repeat (PER) frame(1);
      chk("spawn_valid", note_valid, 8'h01);
      chk("spawn_lane", note_lane[1:0], 2);
      chk("spawn_y", note_y[9:0], 480);

      repeat (222) frame(1);
      chk("move_y0", note_y[9:0], 36);
      chk("move_valid0", note_valid[0], 1);

      press(0);
      chk("wrong_valid0", note_valid[0], 1);
      chk("wrong_y0", note_y[9:0], 36);
      chk("wrong_combo", combo, 0);

      press(2);
      chk("hit_score", score, 1);
      chk("hit_combo", combo, COMBO_ON);
      chk("hit_valid0", note_valid[0], 0);

      // Slot 1 sits at y=96; 36 frames bring it to 24, the next frame expires it.
      repeat (36) frame(1);
      chk("expiry_pre_y1", note_y[19:10], 24);
      chk("expiry_pre_valid1", note_valid[1], 1);
      m0 = miss_cnt;
      frame(1);
      chk("expiry_valid1", note_valid[1], 0);
      chk("expiry_miss", miss_cnt - m0, 1);
      chk("expiry_combo", combo, 0);

      // Two pad lanes and a vsync edge together: two judges then one frame.
      check_en = 1'b0;
      h0  = hit_cnt;
      m0  = miss_cnt;
      nb  = 0;
      pad = 4'b1001;
      vs  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (busy) nb++;
      end
      chk("concurrent_busy", nb, N + 3);
      model_press(0, h1);
      model_press(3, h2);
      model_frame(em);
      pad = 4'd0;
      vs  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("concurrent_hits", hit_cnt - h0, h1 + h2);
      chk("concurrent_misses", miss_cnt - m0, (2 - h1 - h2) + em);
      check_en = 1'b1;

      // Paused game ignores vsync and pads.
      go = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      nb     = 0;
      vs     = 1'b0;
      pad[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (busy) nb++;
      end
      chk("pause_busy", nb, 0);
      vs  = 1'b1;
      pad = 4'd0;
      repeat (5) @(posedge clk);
      #1;
      chk("pause_score_hold", score, 1);

      // Restart clears pool, score and spawn counter but keeps the LFSR.
      check_en = 1'b0;
      go = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      model_clear_pool();
      chk("restart_valid", note_valid, 0);
      chk("restart_score", score, 0);
      check_en = 1'b1;
      repeat (PER) frame(1);
      chk("restart_spawn_valid", note_valid, 8'h01);
      chk("restart_spawn_lane", note_lane[1:0], 3);

      // Reset in the middle of a frame update.
      check_en = 1'b0;
      vs = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (busy) break;
      end
      chk("midrst_busy_seen", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", note_valid, 0);
      vs = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (8) @(posedge clk);
      #1;
      check_en = 1'b1;
      frame(1);

      // Full pool on the second instance: 9 attempts, the 9th dropped.
      repeat (18) frame(2);
      chk("full_valid", note_valid2, 8'hFF);
      chk("full_lanes", note_lane2, 16'hBD26);
      chk("full_y0", note_y2[9:0], 448);
      pad2[2] = 1'b1;
      wait_done(2, nb);
      pad2[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("full_hit_valid", note_valid2, 8'hFE);
      chk("full_hit_score", score2, 1);
      repeat (2) frame(2);
      chk("full_respawn_valid", note_valid2, 8'hFF);
      chk("full_respawn_lane", note_lane2[1:0], 3);
      chk("full_respawn_y", note_y2[9:0], 480);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
